// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative divider: state encoding and the
// quotient pattern returned for a zero divisor.
package div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t FIX  = 2'd2;
  localparam state_t DONE = 2'd3;

  // Wide enough for any practical WIDTH; users slice the low WIDTH bits.
  localparam logic [127:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Handshake and data bundle between the divider and its producer/consumer.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             signed_div;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output flush, in_valid, signed_div, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  flush, in_valid, signed_div, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_divider_cond_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and
// result sign fix-up.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  assign y = en ? (~x + WIDTH'(1)) : x;
endmodule

// File: rtl/seq_divider.sv
// Handshaked restoring divider: one quotient bit per cycle, signed or
// unsigned, with defined divide-by-zero result and synchronous flush.
//
//   state | meaning
//   IDLE  | ready for operands
//   CALC  | one restoring iteration per cycle, WIDTH cycles
//   FIX   | apply result signs or divide-by-zero pattern
//   DONE  | result held until out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs_mag, raw_dvd;
  logic             q_neg, r_neg, dz;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             div_zero_q;

  logic [WIDTH-1:0] dvd_abs, dvs_abs, q_fix, r_fix;
  logic [WIDTH:0]   upper, diff;
  logic             last_iter;

  cond_negate #(.WIDTH(WIDTH)) u_neg_dvd (
    .en (bus.signed_div & bus.dividend[WIDTH-1]),
    .x  (bus.dividend),
    .y  (dvd_abs)
  );

  cond_negate #(.WIDTH(WIDTH)) u_neg_dvs (
    .en (bus.signed_div & bus.divisor[WIDTH-1]),
    .x  (bus.divisor),
    .y  (dvs_abs)
  );

  cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .en (q_neg),
    .x  (quo),
    .y  (q_fix)
  );

  cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .en (r_neg),
    .x  (rem),
    .y  (r_fix)
  );

  // Shifted partial remainder is WIDTH+1 bits so the trial subtract cannot wrap.
  assign upper     = {rem, quo[WIDTH-1]};
  assign diff      = upper - {1'b0, dvs_mag};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = (bus.divisor == '0) ? FIX : CALC;
      CALC: if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.quotient  = quotient_q;
    bus.remainder = remainder_q;
    bus.div_zero  = div_zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs_mag     <= '0;
      raw_dvd     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else if (bus.flush) begin
      cnt         <= '0;
      dz          <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rem     <= '0;
            quo     <= dvd_abs;
            dvs_mag <= dvs_abs;
            raw_dvd <= bus.dividend;
            q_neg   <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg   <= bus.signed_div & bus.dividend[WIDTH-1];
            dz      <= (bus.divisor == '0);
            cnt     <= '0;
          end
        end
        CALC: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= upper[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          quotient_q  <= dz ? DZ_QUOTIENT[WIDTH-1:0] : q_fix;
          remainder_q <= dz ? raw_dvd : r_fix;
          div_zero_q  <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed checks of seq_divider against an arithmetic model.
module tb_seq_divider;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    longint sa, sb;
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      dz = 1'b0;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end
  endfunction

  // Called at a negedge; returns at a negedge with the divider back in IDLE.
  task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] eq, er;
    logic         edz;
    int           n;
    ref_div(sg, a, b, eq, er, edz);
    check_eq("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.signed_div = sg;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.dividend   = $urandom;
    bus.divisor    = $urandom;
    bus.signed_div = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.out_valid && n < 100);
    check_eq("latency", 64'(n), edz ? 64'd1 : 64'(W + 1));
    if (!bus.out_valid) begin
      bus.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b0;
      return;
    end
    check_eq("quotient", 64'(bus.quotient), 64'(eq));
    check_eq("remainder", 64'(bus.remainder), 64'(er));
    check_eq("div_zero", 64'(bus.div_zero), 64'(edz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("hold_quotient", 64'(bus.quotient), 64'(eq));
      check_eq("hold_remainder", 64'(bus.remainder), 64'(er));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("release_valid", 64'(bus.out_valid), 64'd0);
    check_eq("release_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic start_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.signed_div = sg;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid   = 1'b0;
  endtask

  initial begin
    int vcount;
    logic [W-1:0] a, b;
    tests  = 0;
    failed = 0;
    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.signed_div = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_quotient", 64'(bus.quotient), 64'd0);
    check_eq("rst_remainder", 64'(bus.remainder), 64'd0);
    check_eq("rst_div_zero", 64'(bus.div_zero), 64'd0);

    // Directed cases, back to back; the first one exercises backpressure.
    run_op(1'b0, 32'd100, 32'd7, 5);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0);
    run_op(1'b0, 32'hFFFFFFF9, 32'd2, 0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(1'b1, 32'h1234, 32'd0, 1);
    run_op(1'b0, 32'h1234, 32'd0, 0);
    run_op(1'b1, 32'h80000000, 32'd1, 0);
    run_op(1'b0, 32'd5, 32'd9, 0);

    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = W'($urandom_range(0, 3));
        1:       b = 32'hFFFFFFFF;
        2:       b = W'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 1000));
      run_op(1'($urandom), a, b, int'($urandom_range(0, 3)));
    end

    // Flush during CALC: no result ever appears and results are cleared.
    run_op(1'b0, 32'd100, 32'd7, 0);
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check_eq("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("flush_quotient", 64'(bus.quotient), 64'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    check_eq("flush_no_result", 64'(vcount), 64'd0);

    // Flush while a divide-by-zero result is held.
    start_op(1'b0, 32'h55, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("dz_valid", 64'(bus.out_valid), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check_eq("flush_dz_clear", 64'(bus.div_zero), 64'd0);
    check_eq("flush_dz_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-CALC with nonzero held results.
    run_op(1'b0, 32'h1234, 32'd0, 0);
    start_op(1'b1, 32'hFFFF0000, 32'd13);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_quotient", 64'(bus.quotient), 64'd0);
    check_eq("arst_remainder", 64'(bus.remainder), 64'd0);
    check_eq("arst_div_zero", 64'(bus.div_zero), 64'd0);
    check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_in_ready", 64'(bus.in_ready), 64'd1);
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
